// File: rtl/jno_issuer.sv
// Instruction sequencer: fetches {op, operand} words, runs INC/DEC on a counter and
// issues JNO requests to the check unit. Define JNO_ISSUER_STEP_EN for single-step PAUSE.
module jno_issuer #(
  parameter int unsigned AW      = 4,
  parameter int unsigned CW      = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic          pulses,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] prog_addr,
  input  logic [AW+1:0] prog_data,
  output logic [1:0]    instruct,
  output logic          sta,
  input  logic          resp_en,
  input  logic          resp_jump,
  output logic [AW-1:0] pc,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          halted,
  output logic          timeout_err
);

  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    EXEC,
    WAIT_RESP,
    HALT
`ifdef JNO_ISSUER_STEP_EN
    , PAUSE
`endif
  } state_t;

  typedef enum logic [1:0] {
    OP_INC = 2'b00,
    OP_JNO = 2'b01,
    OP_DEC = 2'b10,
    OP_HLT = 2'b11
  } op_t;

`ifdef JNO_ISSUER_STEP_EN
  localparam state_t NEXT_INSTR = PAUSE;
`else
  localparam state_t NEXT_INSTR = FETCH;
`endif

  state_t        state, state_nxt;
  logic [AW+1:0] ir;
  op_t           ir_op;
  logic [AW-1:0] operand;
  logic          sta_frz;
  logic [WW-1:0] wait_cnt;
  logic          wait_expired;

  assign ir_op        = op_t'(ir[AW+1:AW]);
  assign operand      = ir[AW-1:0];
  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_ff @(posedge pulses) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = FETCH;
      FETCH:     state_nxt = WAIT_ROM;
      WAIT_ROM:  state_nxt = EXEC;
      EXEC: begin
        case (ir_op)
          OP_HLT:  state_nxt = HALT;
          OP_JNO:  state_nxt = WAIT_RESP;
          default: state_nxt = NEXT_INSTR;
        endcase
      end
      WAIT_RESP: if (resp_en || wait_expired) state_nxt = NEXT_INSTR;
      HALT:      state_nxt = HALT;
`ifdef JNO_ISSUER_STEP_EN
      PAUSE:     if (start) state_nxt = FETCH;
`endif
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pulses) begin
    if (rst) begin
      pc          <= '0;
      count       <= '0;
      prog_addr   <= '0;
      ir          <= '0;
      sta_frz     <= 1'b1;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc   <= '0;
            busy <= 1'b1;
          end
        end
        FETCH:    prog_addr <= pc;
        WAIT_ROM: ir <= prog_data;
        EXEC: begin
          case (ir_op)
            OP_INC: begin
              count <= count + CW'(1);
              pc    <= pc + AW'(1);
            end
            OP_DEC: begin
              if (count != '0) count <= count - CW'(1);
              pc <= pc + AW'(1);
            end
            OP_HLT: begin
              halted <= 1'b1;
              busy   <= 1'b0;
            end
            default: begin
              sta_frz  <= (count == '0);
              wait_cnt <= '0;
            end
          endcase
        end
        WAIT_RESP: begin
          // resp_jump is only honoured alongside resp_en
          if (resp_en) begin
            pc <= resp_jump ? operand : pc + AW'(1);
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            pc          <= pc + AW'(1);
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    instruct = 2'b00;
    sta      = (count == '0);
    case (state)
      EXEC:      instruct = ir[AW+1:AW];
      WAIT_RESP: begin
        instruct = ir[AW+1:AW];
        sta      = sta_frz;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jno_issuer.sv
// Self-checking bench for jno_issuer: hand table of programs, directed reset/start
// sequences, and random programs against an instruction-level reference model.
module tb_jno_issuer;

  localparam int unsigned AW  = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned TO  = 8;
  localparam int unsigned LEN = 512;

  logic          pulses = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          resp_en = 1'b0;
  logic          resp_jump = 1'b0;
  logic [AW-1:0] prog_addr, pc;
  logic [AW+1:0] prog_data;
  logic [1:0]    instruct;
  logic          sta;
  logic [CW-1:0] count;
  logic          busy, halted, timeout_err;

  logic [AW+1:0] rom [16];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned rsp_d   [64];
  logic        rsp_j   [64];
  logic        rsp_sta [64];
  logic        sta_chk = 1'b0;
  int unsigned epoch = 0;

  bit          cv [LEN];
  int unsigned ep [LEN];
  int unsigned ec [LEN];

  always #5 pulses = ~pulses;

  assign prog_data = rom[prog_addr];

  jno_issuer #(.AW(AW), .CW(CW), .TIMEOUT(TO)) dut (
    .pulses      (pulses),
    .rst         (rst),
    .start       (start),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instruct    (instruct),
    .sta         (sta),
    .resp_en     (resp_en),
    .resp_jump   (resp_jump),
    .pc          (pc),
    .count       (count),
    .busy        (busy),
    .halted      (halted),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Check-unit responder: answers the k-th request in WAIT_RESP cycle rsp_d[k],
  // and toggles resp_jump randomly whenever resp_en is low.
  int unsigned seen_epoch = 0;
  int unsigned occ = 0;
  int unsigned age = 0;
  always @(posedge pulses) begin
    #1;
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      occ = 0;
      age = 0;
    end
    if (instruct == 2'b01) begin
      age++;
      if (sta_chk) chk("sta_during_jno", 32'(sta), 32'(rsp_sta[occ % 64]));
    end else begin
      if (age != 0) occ++;
      age = 0;
    end
    resp_en   = (age >= 2) && (age == rsp_d[occ % 64] + 2);
    resp_jump = resp_en ? rsp_j[occ % 64] : 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge pulses);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    epoch++;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, 32'(pc), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_prog_addr"}, 32'(prog_addr), 0);
    chk({tag, "_instruct"}, 32'(instruct), 0);
    chk({tag, "_sta"}, 32'(sta), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  // Instruction-level model: each instruction costs 3 cycles, a JNO answered in
  // wait cycle d costs 4+d, an unanswered JNO costs 3+TO. Checks pc/count at each
  // instruction boundary.
  task automatic run_prog(input int unsigned max_instr, input string tag);
    int unsigned mpc, mcnt, e, k, d, last;
    logic [5:0]  w;
    bit          mh, mt;
    mpc = 0; mcnt = 0; e = 0; k = 0; mh = 0; mt = 0;
    for (int i = 0; i < LEN; i++) cv[i] = 0;
    for (int n = 0; n < max_instr && !mh; n++) begin
      w = rom[mpc];
      case (w[5:4])
        2'b00: begin mcnt = (mcnt + 1) % 16; mpc = (mpc + 1) % 16; e += 3; end
        2'b10: begin if (mcnt > 0) mcnt--; mpc = (mpc + 1) % 16; e += 3; end
        2'b11: begin mh = 1; e += 3; end
        default: begin
          rsp_sta[k] = (mcnt == 0);
          d = rsp_d[k];
          if (d < TO) begin
            e += 4 + d;
            mpc = rsp_j[k] ? int'(w[3:0]) : (mpc + 1) % 16;
          end else begin
            e += 3 + TO;
            mt = 1;
            mpc = (mpc + 1) % 16;
          end
          k++;
        end
      endcase
      cv[e] = 1; ep[e] = mpc; ec[e] = mcnt;
    end
    last = mh ? e + 2 : e;
    sta_chk = 1'b1;
    do_reset();
    kick();
    for (int i = 1; i <= int'(last); i++) begin
      step();
      if (cv[i]) begin
        chk({tag, "_pc"}, 32'(pc), ep[i]);
        chk({tag, "_count"}, 32'(count), ec[i]);
      end
    end
    chk({tag, "_halted"}, 32'(halted), 32'(mh));
    chk({tag, "_busy"}, 32'(busy), 32'(!mh));
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(mt));
  endtask

  typedef struct {
    string          name;
    logic [15:0][5:0] prog;
    int unsigned    d;
    logic [1:0]     jmp;
    logic           has_sta;
    logic           sta_v;
    int unsigned    end_edge;
    logic [3:0]     pc;
    logic [3:0]     cnt;
    logic           h;
    logic           b;
    logic           t;
  } vec_t;

  vec_t tbl [6];

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 6'b110000;
    for (int i = 0; i < 64; i++) begin
      rsp_d[i] = 99; rsp_j[i] = 1'b0; rsp_sta[i] = 1'b0;
    end

    for (int i = 0; i < 6; i++) begin
      tbl[i].prog = {16{6'b110000}};
      tbl[i].d = 99; tbl[i].jmp = 2'b00; tbl[i].has_sta = 1'b0; tbl[i].sta_v = 1'b0;
    end
    tbl[0].name = "basic";
    tbl[0].prog[0] = 6'b000000; tbl[0].prog[1] = 6'b000000;
    tbl[0].prog[2] = 6'b100000; tbl[0].prog[3] = 6'b110000;
    tbl[0].end_edge = 12; tbl[0].pc = 3; tbl[0].cnt = 1;
    tbl[0].h = 1; tbl[0].b = 0; tbl[0].t = 0;

    tbl[1].name = "jno_taken";
    tbl[1].prog[0] = 6'b010101; tbl[1].prog[5] = 6'b110000;
    tbl[1].d = 1; tbl[1].jmp = 2'b11; tbl[1].has_sta = 1; tbl[1].sta_v = 1;
    tbl[1].end_edge = 8; tbl[1].pc = 5; tbl[1].cnt = 0;
    tbl[1].h = 1; tbl[1].b = 0; tbl[1].t = 0;

    tbl[2].name = "jno_not_taken";
    tbl[2].prog[0] = 6'b000000; tbl[2].prog[1] = 6'b000000; tbl[2].prog[2] = 6'b000000;
    tbl[2].prog[3] = 6'b010101; tbl[2].prog[4] = 6'b110000; tbl[2].prog[5] = 6'b000000;
    tbl[2].d = 1; tbl[2].jmp = 2'b00; tbl[2].has_sta = 1; tbl[2].sta_v = 0;
    tbl[2].end_edge = 17; tbl[2].pc = 4; tbl[2].cnt = 3;
    tbl[2].h = 1; tbl[2].b = 0; tbl[2].t = 0;

    tbl[3].name = "jno_timeout";
    tbl[3].prog[0] = 6'b010111; tbl[3].prog[1] = 6'b110000; tbl[3].prog[7] = 6'b000000;
    tbl[3].d = 99; tbl[3].jmp = 2'b11; tbl[3].has_sta = 1; tbl[3].sta_v = 1;
    tbl[3].end_edge = 14; tbl[3].pc = 1; tbl[3].cnt = 0;
    tbl[3].h = 1; tbl[3].b = 0; tbl[3].t = 1;

    tbl[4].name = "dec_sat_pc_wrap";
    tbl[4].prog[0] = 6'b100000; tbl[4].prog[1] = 6'b011111;
    tbl[4].prog[2] = 6'b110000; tbl[4].prog[15] = 6'b000000;
    tbl[4].d = 0; tbl[4].jmp = 2'b01; tbl[4].has_sta = 1; tbl[4].sta_v = 1;
    tbl[4].end_edge = 20; tbl[4].pc = 2; tbl[4].cnt = 0;
    tbl[4].h = 1; tbl[4].b = 0; tbl[4].t = 0;

    tbl[5].name = "inc_wrap";
    tbl[5].prog = {16{6'b000000}};
    tbl[5].end_edge = 48; tbl[5].pc = 0; tbl[5].cnt = 0;
    tbl[5].h = 0; tbl[5].b = 1; tbl[5].t = 0;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) rom[i] = tbl[v].prog[i];
      for (int i = 0; i < 64; i++) begin
        rsp_d[i]   = tbl[v].d;
        rsp_j[i]   = (i < 2) ? tbl[v].jmp[i] : 1'b0;
        rsp_sta[i] = tbl[v].sta_v;
      end
      sta_chk = tbl[v].has_sta;
      do_reset();
      chk_reset_state({tbl[v].name, "_rst"});
      kick();
      for (int i = 1; i <= int'(tbl[v].end_edge); i++) step();
      chk({tbl[v].name, "_pc"}, 32'(pc), 32'(tbl[v].pc));
      chk({tbl[v].name, "_count"}, 32'(count), 32'(tbl[v].cnt));
      chk({tbl[v].name, "_halted"}, 32'(halted), 32'(tbl[v].h));
      chk({tbl[v].name, "_busy"}, 32'(busy), 32'(tbl[v].b));
      chk({tbl[v].name, "_timeout_err"}, 32'(timeout_err), 32'(tbl[v].t));
    end

    // Reset in the middle of a JNO wait, then restart; start while busy and in HALT is ignored.
    for (int i = 0; i < 16; i++) rom[i] = 6'b110000;
    rom[0] = 6'b000000;
    rom[1] = 6'b011001;
    for (int i = 0; i < 64; i++) begin rsp_d[i] = 99; rsp_sta[i] = 1'b0; end
    sta_chk = 1'b1;
    do_reset();
    kick();
    for (int i = 0; i < 7; i++) step();
    chk("midwait_instruct", 32'(instruct), 1);
    chk("midwait_prog_addr", 32'(prog_addr), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("midwait_rst");
    kick();
    chk("restart_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) step();
    chk("restart_pc", 32'(pc), 1);
    chk("restart_count", 32'(count), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("restart_halted", 32'(halted), 1);
    chk("restart_pc_end", 32'(pc), 2);
    chk("restart_timeout_err", 32'(timeout_err), 1);
    chk("restart_busy_end", 32'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("halt_start_halted", 32'(halted), 1);
    chk("halt_start_busy", 32'(busy), 0);
    chk("halt_start_pc", 32'(pc), 2);

    // Model-checked runs: the basic program, then random programs and responses.
    for (int i = 0; i < 16; i++) rom[i] = 6'b110000;
    rom[0] = 6'b000000; rom[1] = 6'b000000; rom[2] = 6'b100000; rom[3] = 6'b110000;
    run_prog(24, "model_basic");

    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < 16; i++) begin
        int unsigned x;
        logic [1:0]  op;
        x  = $urandom_range(0, 99);
        op = (x < 35) ? 2'b00 : (x < 60) ? 2'b10 : (x < 90) ? 2'b01 : 2'b11;
        rom[i] = {op, 4'($urandom_range(0, 15))};
      end
      for (int i = 0; i < 64; i++) begin
        rsp_d[i] = $urandom_range(0, 10);
        rsp_j[i] = 1'($urandom_range(0, 1));
      end
      run_prog(24, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
